// File: rtl/branch_predict_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predict_unit_if
//  Purpose  : Bundle between pipeline (fetch / EX / ALU) and the branch
//             predict unit: flag write port, fetch prediction read port,
//             EX resolution port and the redirect/statistics outputs.
//  Revision : 1.0 - initial release
// ============================================================================
interface branch_predict_unit_if #(
    parameter int PC_W   = 16,
    parameter int STAT_W = 16
);
    // ALU flag write port, bit order [N,Z,V]
    logic [2:0]        flag_we;
    logic [2:0]        flag_in;
    logic [2:0]        flags_out;
    // fetch prediction port
    logic [PC_W-1:0]   pred_pc;
    logic              pred_taken;
    // EX resolution port
    logic              res_valid;
    logic [PC_W-1:0]   res_pc;
    logic [2:0]        res_cond;
    logic              res_pred_taken;
    logic [PC_W-1:0]   res_target;
    logic [PC_W-1:0]   res_fallthru;
    // redirect / status
    logic              mispredict;
    logic [PC_W-1:0]   redirect_pc;
    logic              taken_q;
    logic [STAT_W-1:0] mispred_cnt;

    // pipeline side
    modport master (
        output flag_we, flag_in, pred_pc,
        output res_valid, res_pc, res_cond, res_pred_taken, res_target, res_fallthru,
        input  flags_out, pred_taken, mispredict, redirect_pc, taken_q, mispred_cnt
    );

    // predictor side
    modport slave (
        input  flag_we, flag_in, pred_pc,
        input  res_valid, res_pc, res_cond, res_pred_taken, res_target, res_fallthru,
        output flags_out, pred_taken, mispredict, redirect_pc, taken_q, mispred_cnt
    );
endinterface
`default_nettype wire

// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predict_unit
//  Purpose  : Owns the N/Z/V flag register and a direct-mapped table of
//             2-bit saturating counters. Resolves EX branches against the
//             bypassed flags, registers mispredict/redirect, trains the
//             table and keeps a saturating mispredict count.
//  Revision : 1.0 - initial release
// ============================================================================
module branch_predict_unit #(
    parameter int         PC_W     = 16,
    parameter int         IDX_W    = 4,
    parameter logic [1:0] CNT_INIT = 2'b01,
    parameter int         STAT_W   = 16
) (
    input  wire logic clk,
    input  wire logic rst,
    branch_predict_unit_if.slave bus
);

    localparam int                c_depth    = 1 << IDX_W;
    localparam logic [STAT_W-1:0] c_stat_max = {STAT_W{1'b1}};

    logic [2:0]        r_flags;
    logic [1:0]        r_table [c_depth];
    logic              r_mispredict;
    logic [PC_W-1:0]   r_redirect_pc;
    logic              r_taken;
    logic [STAT_W-1:0] r_mispred_cnt;

    logic [2:0]        w_eff;
    logic              w_n;
    logic              w_z;
    logic              w_v;
    logic              w_actual;
    logic              w_mis;
    logic [IDX_W-1:0]  w_res_idx;
    logic [IDX_W-1:0]  w_pred_idx;
    logic [1:0]        w_cnt_old;
    logic [1:0]        w_cnt_new;
    logic              w_unused_pc_bits;

    // A flag written this cycle is seen by a branch resolving this cycle.
    assign w_eff = (bus.flag_we & bus.flag_in) | (~bus.flag_we & r_flags);
    assign w_n   = w_eff[2];
    assign w_z   = w_eff[1];
    assign w_v   = w_eff[0];

    // PCs are halfword aligned, so bit 0 never selects an entry.
    assign w_res_idx  = bus.res_pc[IDX_W:1];
    assign w_pred_idx = bus.pred_pc[IDX_W:1];
    assign w_unused_pc_bits = ^{bus.res_pc[PC_W-1:IDX_W+1], bus.res_pc[0],
                                bus.pred_pc[PC_W-1:IDX_W+1], bus.pred_pc[0]};

    // Branch condition decode from the bypassed flags.
    always_comb begin
        w_actual = 1'b0;
        case (bus.res_cond)
            3'b000:  w_actual = ~w_z;
            3'b001:  w_actual = w_z;
            3'b010:  w_actual = ~w_z & ~w_n;
            3'b011:  w_actual = w_n;
            3'b100:  w_actual = w_z | ~w_n;
            3'b101:  w_actual = w_n | w_z;
            3'b110:  w_actual = w_v;
            default: w_actual = 1'b1;
        endcase
    end

    assign w_mis = w_actual != bus.res_pred_taken;

    // Saturating counter step toward the resolved outcome.
    always_comb begin
        w_cnt_old = r_table[w_res_idx];
        w_cnt_new = w_cnt_old;
        if (w_actual) begin
            if (w_cnt_old != 2'b11) w_cnt_new = w_cnt_old + 2'd1;
        end else begin
            if (w_cnt_old != 2'b00) w_cnt_new = w_cnt_old - 2'd1;
        end
    end

    // Flag register, predictor table and resolution outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags       <= 3'b000;
            r_mispredict  <= 1'b0;
            r_redirect_pc <= '0;
            r_taken       <= 1'b0;
            r_mispred_cnt <= '0;
            for (int i = 0; i < c_depth; i++) begin
                r_table[i] <= CNT_INIT;
            end
        end else begin
            r_flags <= w_eff;
            if (bus.res_valid) begin
                r_taken              <= w_actual;
                r_mispredict         <= w_mis;
                r_redirect_pc        <= w_actual ? bus.res_target : bus.res_fallthru;
                r_table[w_res_idx]   <= w_cnt_new;
                if (w_mis && (r_mispred_cnt != c_stat_max)) begin
                    r_mispred_cnt <= r_mispred_cnt + 1'b1;
                end
            end else begin
                r_mispredict <= 1'b0;
            end
        end
    end

    // Prediction reads the pre-update counter.
    assign bus.pred_taken  = r_table[w_pred_idx][1];
    assign bus.flags_out   = r_flags;
    assign bus.mispredict  = r_mispredict;
    assign bus.redirect_pc = r_redirect_pc;
    assign bus.taken_q     = r_taken;
    assign bus.mispred_cnt = r_mispred_cnt;

endmodule
`default_nettype wire

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
Parametrised successor to the combinational branch-condition evaluator. It owns the architectural N/Z/V flag register and a direct-mapped table of 2-bit saturating predictor counters. It resolves branches in EX against the bypassed flags and raises a registered mispredict/redirect to fetch. Fetch reads a prediction each cycle; EX updates the table and a saturating mispredict counter.

Parameters:
PC_W, 16, width of PC and branch target buses
IDX_W, 4, predictor index width; table depth = 2**IDX_W entries, indexed by pc[IDX_W:1]
CNT_INIT, 2'b01, reset value of every counter (weakly not-taken)
STAT_W, 16, width of saturating mispredict statistics counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
flag_we  in  3  per-flag write enable from ALU, bit order [N,Z,V]
flag_in  in  3  new flag values from ALU [N,Z,V]
flags_out  out  3  registered flag register [N,Z,V]
pred_pc  in  PC_W  fetch PC to predict
pred_taken  out  1  combinational: MSB of counter at pred_pc index
res_valid  in  1  EX holds a branch to resolve this cycle
res_pc  in  PC_W  PC of resolving branch
res_cond  in  3  condition code ccc
res_pred_taken  in  1  prediction carried down the pipe for this branch
res_target  in  PC_W  taken target
res_fallthru  in  PC_W  not-taken PC
mispredict  out  1  registered one-cycle pulse
redirect_pc  out  PC_W  registered correct next PC, valid while mispredict=1
taken_q  out  1  registered actual outcome of last resolved branch
mispred_cnt  out  STAT_W  saturating count of mispredicts

Behaviour:
- Reset (rst=1 at edge): flags_out=3'b000; all counters=CNT_INIT; mispredict=0; redirect_pc=0; taken_q=0; mispred_cnt=0. Reset dominates every other input, including in-flight res_valid.
- Flag register: per bit i, flags_q[i] <= flag_we[i] ? flag_in[i] : flags_q[i]. Bits with flag_we=0 hold their value.
- Bypass: resolution uses eff[i] = flag_we[i] ? flag_in[i] : flags_q[i]. This covers a flag write and a branch in the same cycle.
- Condition decode from eff (N,Z,V):
  - 000 = ~Z
  - 001 = Z
  - 010 = ~Z & ~N
  - 011 = N
  - 100 = Z | ~N
  - 101 = N | Z
  - 110 = V
  - 111 = 1
- Resolution, when res_valid=1, registered with 1-cycle latency:
  - taken_q <= actual.
  - mispredict <= (actual != res_pred_taken).
  - redirect_pc <= actual ? res_target : res_fallthru.
  - Counter at res_pc[IDX_W:1]: actual=1 increments, saturating at 2'b11; actual=0 decrements, saturating at 2'b00.
  - mispred_cnt increments on mispredict and saturates at all-ones.
- When res_valid=0: mispredict <= 0; taken_q, redirect_pc and the table hold.
- Prediction read is combinational and returns the pre-update value. A read and update of the same index in one cycle returns the old counter; the new value is visible the next cycle.
- Unconditional (111) is treated like any other branch. It trains toward taken and mispredicts if it was predicted not-taken.
- Back-to-back res_valid is legal every cycle. mispredict may be high on consecutive cycles. Upstream flush is the pipeline's job; this block does not gate res_valid.
- Aliasing: PCs sharing pc[IDX_W:1] share a counter. No tags.

Test Plan:
- Reset then pred_pc=0x0010 -> pred_taken=0 (CNT_INIT=01); flags_out=000, mispred_cnt=0.
- flag_we=010, flag_in=010 with res_valid=1, res_cond=001, res_pred_taken=0, res_target=0x0040, res_fallthru=0x0022 -> next cycle mispredict=1, redirect_pc=0x0040, taken_q=1, flags_out=010, mispred_cnt=1.
- Three taken resolves at res_pc=0x0020 -> counter 01→10→11→11 (saturates); pred_pc=0x0020 gives pred_taken=1 after the first update; a later not-taken leaves pred_taken=1 (counter 10).
- Sweep all 8 res_cond over all 8 flag values -> taken_q matches the decode table; mispredict=1 exactly where actual≠res_pred_taken.
- Same-cycle read/update at index 3: pred_taken shows the old MSB; the following cycle shows the new MSB.
- rst asserted the cycle res_valid=1 mispredicts -> next cycle mispredict=0, mispred_cnt=0, counters=01; force STAT_W=4, 20 mispredicts -> mispred_cnt=15.
